// File: rtl/vec_pkg.sv
// ============================================================================
// Module : vec_pkg
// Brief  : Shared ALU codes, sequencer states and lane packing helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        MOV = 3'b010,
        MUL = 3'b011,
        DIV = 3'b100,
        CMP = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Bit offset of a lane inside a packed vector (lane i at [i*width +: width]).
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic logic lane_is_last(input int lane, input int lanes);
        return (lane == lanes - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_lane_collect.sv
// ============================================================================
// Module : vec_lane_collect
// Brief  : Result register file, one N-bit register per lane with lane-indexed
//          write enable; cleared by reset and by accept of a new operation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_lane_collect #(
    parameter int N     = 8,
    parameter int LANES = 4,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               we_i,
    input  logic [LW-1:0]      lane_i,
    input  logic [N-1:0]       data_i,
    output logic [LANES*N-1:0] result_o
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [N-1:0] lane_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q <= '0;
            end else if (clr_i) begin
                lane_q <= '0;
            end else if (we_i && (lane_i == LW'(i))) begin
                lane_q <= data_i;
            end
        end

        assign result_o[i*N +: N] = lane_q;
    end

endmodule

`default_nettype wire

// File: rtl/vec_lane_sequencer.sv
// ============================================================================
// Module : vec_lane_sequencer
// Brief  : Streams one vector op lane-by-lane through a scalar ALU and returns
//          the collected result vector over valid/ready.
//          Optional macro DIVZERO_CHECK_EN adds per-lane divide-by-zero flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_lane_sequencer
    import vec_pkg::*;
#(
    parameter int N     = 8,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [LANES*N-1:0] in_a,
    input  logic [LANES*N-1:0] in_b,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    output logic [2:0]         alu_f,
    input  logic [N-1:0]       alu_result,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef DIVZERO_CHECK_EN
    output logic [LANES-1:0]   divz,
`endif
    output logic [LANES*N-1:0] out_result,
    output logic               busy
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VW = (LANES * N > 1) ? $clog2(LANES * N) : 1;

    seq_state_e         state_q, state_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic [2:0]         op_q;
    logic [LANES*N-1:0] a_q, b_q;

    logic               w_accept;
    logic               w_run;
    logic [VW-1:0]      w_lsb;
    logic [N-1:0]       w_lane_a, w_lane_b;
    logic [N-1:0]       w_wr_data;

    assign w_accept = (state_q == IDLE) && in_valid;
    assign w_run    = (state_q == RUN);
    assign w_lsb    = VW'(lane_lsb(int'(lane_q), N));
    assign w_lane_a = a_q[w_lsb +: N];
    assign w_lane_b = b_q[w_lsb +: N];

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    lane_d  = '0;
                end
            end
            RUN: begin
                // Counter parks on the last lane instead of wrapping.
                if (lane_is_last(int'(lane_q), LANES)) begin
                    state_d = DONE;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (w_accept) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
        end
    end

`ifdef DIVZERO_CHECK_EN
    logic             w_divz_hit;
    logic [LANES-1:0] divz_q;

    assign w_divz_hit = w_run && (op_q == DIV) && (w_lane_b == '0);
    assign w_wr_data  = w_divz_hit ? {N{1'b1}} : alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divz_q <= '0;
        end else if (w_accept) begin
            divz_q <= '0;
        end else if (w_divz_hit) begin
            divz_q[lane_q] <= 1'b1;
        end
    end

    assign divz = divz_q;
`else
    assign w_wr_data = alu_result;
`endif

    vec_lane_collect #(
        .N     (N),
        .LANES (LANES),
        .LW    (LW)
    ) u_collect (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (w_accept),
        .we_i     (w_run),
        .lane_i   (lane_q),
        .data_i   (w_wr_data),
        .result_o (out_result)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign alu_a     = w_run ? w_lane_a : '0;
    assign alu_b     = w_run ? w_lane_b : '0;
    assign alu_f     = op_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_lane_sequencer.sv
// ============================================================================
// Module : tb_vec_lane_sequencer
// Brief  : Directed self-checking bench with a behavioural scalar ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_lane_sequencer;

    localparam int N     = 8;
    localparam int LANES = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [LANES*N-1:0] in_a, in_b;
    logic [N-1:0]       alu_a, alu_b, alu_result;
    logic [2:0]         alu_f;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*N-1:0] out_result;
    logic               busy;
`ifdef DIVZERO_CHECK_EN
    logic [LANES-1:0]   divz;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vec_lane_sequencer #(.N(N), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef DIVZERO_CHECK_EN
        .divz       (divz),
`endif
        .out_result (out_result),
        .busy       (busy)
    );

    // Scalar ALU consumer; results truncate to N bits.
    always_comb begin
        case (alu_f)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_b;
            3'b011:  alu_result = N'(alu_a * alu_b);
            3'b100:  alu_result = (alu_b == '0) ? '0 : alu_a / alu_b;
            3'b101:  alu_result = (alu_a < alu_b) ? N'(1) : '0;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept an op, verify cycle-exact latency, then verify the result in DONE.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        @(negedge clk);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lane0_a"}, 64'(alu_a), 64'(a[7:0]));
        check({tag, "_lane0_b"}, 64'(alu_b), 64'(b[7:0]));
        for (int k = 1; k <= LANES; k++) begin
            @(posedge clk); #1;
            check({tag, "_rdy_vld"}, 64'({in_ready, out_valid}),
                  (k == LANES) ? 64'b01 : 64'b00);
        end
        check({tag, "_result"}, 64'(out_result), 64'(exp));
    endtask

    task automatic release_done(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_idle_rdy_vld"}, 64'({in_ready, out_valid, busy}), 64'b100);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        int          accept2;
        int          nres;
        logic [31:0] res [2];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 64'({out_valid, busy, alu_a, alu_b, alu_f}), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Add
        run_op("add", 3'b000, 32'h04030201, 32'h0A141E28, 32'h0E172029);
        release_done("add");

        // Mul wrap and MOV
        run_op("mul", 3'b011, 32'h10101010, 32'h10101010, 32'h00000000);
        release_done("mul");
        run_op("mov", 3'b010, 32'h55555555, 32'h09080706, 32'h09080706);
        release_done("mov");
        check("idle_alu_ab", 64'({alu_a, alu_b}), 64'd0);
        check("idle_alu_f_hold", 64'(alu_f), 64'd2);

        // Backpressure, with an ignored in_valid pulse
        run_op("bp", 3'b000, 32'h01010101, 32'h01020304, 32'h02030405);
        held = out_result;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) begin
                in_valid = 1'b1;
                in_op    = 3'b001;
                in_a     = 32'hFFFFFFFF;
                in_b     = 32'h11111111;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_hold_vld", 64'({out_valid, in_ready}), 64'b10);
            check("bp_hold_res", 64'(out_result), 64'(held));
        end
        in_valid = 1'b0;
        release_done("bp");
        check("bp_op_not_sampled", 64'(alu_f), 64'd0);

        // Reset mid-RUN at lane 2
        @(negedge clk);
        in_op    = 3'b000;
        in_a     = 32'h01010101;
        in_b     = 32'h01010101;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", 64'({out_valid, busy}), 64'd0);
        check("mid_rst_result", 64'(out_result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        run_op("ones_p1", 3'b000, 32'hFFFFFFFF, 32'h01010101, 32'h00000000);
        release_done("ones_p1");

        // Back-to-back with in_valid held and out_ready tied high
        accept2 = -1;
        nres    = 0;
        @(negedge clk);
        in_op     = 3'b001;
        in_a      = 32'h0A0A0A0A;
        in_b      = 32'h01020304;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_op = 3'b000;
        in_a  = 32'h11223344;
        in_b  = 32'h01010101;
        for (int k = 1; k <= 16; k++) begin
            if (out_valid && nres < 2) begin
                res[nres] = out_result;
                nres++;
            end
            if (in_ready && accept2 < 0) begin
                accept2 = k;
            end else if (accept2 >= 0) begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accept_gap", 64'(accept2), 64'(LANES + 2));
        check("b2b_nres", 64'(nres), 64'd2);
        check("b2b_res0", 64'(res[0]), 64'h09080706);
        check("b2b_res1", 64'(res[1]), 64'h12233445);

`ifdef DIVZERO_CHECK_EN
        run_op("div", 3'b100, 32'h08080808, 32'h02040001, 32'h0402FF08);
        check("div_divz", 64'(divz), 64'b0010);
        release_done("div");
        run_op("div_clr", 3'b000, 32'h00000000, 32'h00000000, 32'h00000000);
        check("divz_clear", 64'(divz), 64'b0000);
        release_done("div_clr");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
